branch_resolver: RTL and testbench

Execute-stage unit that closes the loop on the branch predictor. It compares the prediction carried down the pipeline with the actual branch outcome, and drives the registered feedback bus (enable/taken/target/pc) back to the predictor. On a mispredict it issues a redirect PC and a multi-cycle pipeline flush. It also keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_resolver.sv | 156 +++++++++++++++
 tb/tb_branch_resolver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: predictor feedback, mispredict redirect,
// multi-cycle flush FSM and saturating branch/mispredict statistics.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   ex_valid/ex_is_branch : execute-stage instruction qualifiers
//   ex_pc/ex_taken/ex_target : actual outcome of the instruction
//   ex_pred_*             : prediction captured at fetch
//   feedback_*            : registered one-cycle predictor update bus
//   redirect_valid/_pc    : registered fetch redirect on mispredict
//   flush                 : squash younger stages for FLUSH_CYCLES cycles
//   branch_count, mispredict_count : saturating statistics
module branch_resolver #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_opinion,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_addr,
    output logic             feedback_enable,
    output logic             feedback_branch_taken,
    output logic [31:0]      feedback_branch_addr,
    output logic [31:0]      feedback_current_pc,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     fcnt_q, fcnt_d;

    logic              fb_en_q;
    logic              fb_taken_q;
    logic [31:0]       fb_addr_q;
    logic [31:0]       fb_pc_q;
    logic              rd_valid_q;
    logic [31:0]       rd_pc_q;
    logic [CNT_W-1:0]  br_cnt_q;
    logic [CNT_W-1:0]  mp_cnt_q;

    logic              accept;
    logic              fb_fire;
    logic              mispredict;
    logic [31:0]       pc_plus4;
    logic [31:0]       pnpc;
    logic [31:0]       anpc;

    // Inputs are only looked at in IDLE; during FLUSH the stage
    // holds squashed instructions whose outcome is meaningless.
    assign accept   = (state_q == IDLE);
    assign pc_plus4 = ex_pc + 32'd4;
    assign pnpc     = (ex_pred_opinion && ex_pred_taken) ? ex_pred_addr : pc_plus4;
    assign anpc     = (ex_is_branch && ex_taken) ? ex_target : pc_plus4;

    assign fb_fire    = ex_valid && ex_is_branch && accept;
    // Also catches a stale taken prediction on a non-branch.
    assign mispredict = ex_valid && accept && (pnpc != anpc);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // FSM next state: FLUSH lasts FLUSH_LOAD+1 cycles
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q - FW'(1);
                end
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        flush = 1'b0;
        unique case (state_q)
            IDLE:  flush = 1'b0;
            FLUSH: flush = 1'b1;
        endcase
    end

    // Registered feedback, redirect and statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            fb_en_q    <= 1'b0;
            fb_taken_q <= 1'b0;
            fb_addr_q  <= '0;
            fb_pc_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_pc_q    <= '0;
            br_cnt_q   <= '0;
            mp_cnt_q   <= '0;
        end else begin
            fb_en_q    <= fb_fire;
            rd_valid_q <= mispredict;
            if (fb_fire) begin
                fb_taken_q <= ex_taken;
                fb_addr_q  <= ex_target;
                fb_pc_q    <= ex_pc;
            end
            if (mispredict) begin
                rd_pc_q <= anpc;
            end
            if (fb_fire && (br_cnt_q != {CNT_W{1'b1}})) begin
                br_cnt_q <= br_cnt_q + CNT_W'(1);
            end
            if (mispredict && (mp_cnt_q != {CNT_W{1'b1}})) begin
                mp_cnt_q <= mp_cnt_q + CNT_W'(1);
            end
        end
    end

    assign feedback_enable       = fb_en_q;
    assign feedback_branch_taken = fb_taken_q;
    assign feedback_branch_addr  = fb_addr_q;
    assign feedback_current_pc   = fb_pc_q;
    assign redirect_valid        = rd_valid_q;
    assign redirect_pc           = rd_pc_q;
    assign branch_count          = br_cnt_q;
    assign mispredict_count      = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Testbench for branch_resolver: vector table plus hand sequences,
// expected results queued at drive time and compared after each edge.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_opinion;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_addr;

    logic        fb_en, fb_tk, rd_v, fl;
    logic [31:0] fb_addr, fb_pc, rd_pc, bc, mc;

    logic        d2_fb_en, d2_fb_tk, d2_rd_v, d2_fl;
    logic [31:0] d2_fb_addr, d2_fb_pc, d2_rd_pc;
    logic [1:0]  d2_bc, d2_mc;

    always #5 clk = ~clk;

    branch_resolver dut (
        .clk                   (clk),
        .reset                 (reset),
        .ex_valid              (ex_valid),
        .ex_is_branch          (ex_is_branch),
        .ex_pc                 (ex_pc),
        .ex_taken              (ex_taken),
        .ex_target             (ex_target),
        .ex_pred_opinion       (ex_pred_opinion),
        .ex_pred_taken         (ex_pred_taken),
        .ex_pred_addr          (ex_pred_addr),
        .feedback_enable       (fb_en),
        .feedback_branch_taken (fb_tk),
        .feedback_branch_addr  (fb_addr),
        .feedback_current_pc   (fb_pc),
        .redirect_valid        (rd_v),
        .redirect_pc           (rd_pc),
        .flush                 (fl),
        .branch_count          (bc),
        .mispredict_count      (mc)
    );

    branch_resolver #(.CNT_W(2)) dut2 (
        .clk                   (clk),
        .reset                 (reset),
        .ex_valid              (ex_valid),
        .ex_is_branch          (ex_is_branch),
        .ex_pc                 (ex_pc),
        .ex_taken              (ex_taken),
        .ex_target             (ex_target),
        .ex_pred_opinion       (ex_pred_opinion),
        .ex_pred_taken         (ex_pred_taken),
        .ex_pred_addr          (ex_pred_addr),
        .feedback_enable       (d2_fb_en),
        .feedback_branch_taken (d2_fb_tk),
        .feedback_branch_addr  (d2_fb_addr),
        .feedback_current_pc   (d2_fb_pc),
        .redirect_valid        (d2_rd_v),
        .redirect_pc           (d2_rd_pc),
        .flush                 (d2_fl),
        .branch_count          (d2_bc),
        .mispredict_count      (d2_mc)
    );

    typedef struct {
        logic        rst, v, br, tk, op, pt;
        logic [31:0] pc, tgt, pa;
    } in_t;

    typedef struct {
        logic        fb, fbt, rv, fl;
        logic [31:0] fba, fbpc, rpc, bc, mc;
        logic        sat;
        logic [1:0]  bc2, mc2;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    exp_t sb[$];
    vec_t vt[15];
    int   pass  = 0;
    int   total = 0;

    function automatic in_t mi(logic rst, logic v, logic br,
                               logic [31:0] pc, logic tk,
                               logic [31:0] tgt, logic op,
                               logic pt, logic [31:0] pa);
        in_t r;
        r.rst = rst; r.v = v; r.br = br; r.pc = pc;
        r.tk = tk; r.tgt = tgt; r.op = op; r.pt = pt; r.pa = pa;
        return r;
    endfunction

    function automatic exp_t me(logic fb, logic fbt,
                                logic [31:0] fba, logic [31:0] fbpc,
                                logic rv, logic [31:0] rpc, logic fl,
                                logic [31:0] bcv, logic [31:0] mcv);
        exp_t r;
        r.fb = fb; r.fbt = fbt; r.fba = fba; r.fbpc = fbpc;
        r.rv = rv; r.rpc = rpc; r.fl = fl; r.bc = bcv; r.mc = mcv;
        r.sat = 1'b0; r.bc2 = 2'd0; r.mc2 = 2'd0;
        return r;
    endfunction

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a === e) pass++;
        else $display("FAIL %s: got %h want %h", n, a, e);
    endtask

    task automatic compare(input exp_t e, input string tag);
        chk({tag, " fb_en"}, {31'd0, fb_en}, {31'd0, e.fb});
        chk({tag, " fb_taken"}, {31'd0, fb_tk}, {31'd0, e.fbt});
        chk({tag, " fb_addr"}, fb_addr, e.fba);
        chk({tag, " fb_pc"}, fb_pc, e.fbpc);
        chk({tag, " rd_valid"}, {31'd0, rd_v}, {31'd0, e.rv});
        chk({tag, " rd_pc"}, rd_pc, e.rpc);
        chk({tag, " flush"}, {31'd0, fl}, {31'd0, e.fl});
        chk({tag, " br_cnt"}, bc, e.bc);
        chk({tag, " mp_cnt"}, mc, e.mc);
        if (e.sat) begin
            chk({tag, " d2 fb_en"}, {31'd0, d2_fb_en}, {31'd0, e.fb});
            chk({tag, " d2 fb_taken"}, {31'd0, d2_fb_tk}, {31'd0, e.fbt});
            chk({tag, " d2 fb_addr"}, d2_fb_addr, e.fba);
            chk({tag, " d2 fb_pc"}, d2_fb_pc, e.fbpc);
            chk({tag, " d2 rd_valid"}, {31'd0, d2_rd_v}, {31'd0, e.rv});
            chk({tag, " d2 rd_pc"}, d2_rd_pc, e.rpc);
            chk({tag, " d2 flush"}, {31'd0, d2_fl}, {31'd0, e.fl});
            chk({tag, " d2 br_cnt"}, {30'd0, d2_bc}, {30'd0, e.bc2});
            chk({tag, " d2 mp_cnt"}, {30'd0, d2_mc}, {30'd0, e.mc2});
        end
    endtask

    task automatic drive(input in_t i);
        reset           = i.rst;
        ex_valid        = i.v;
        ex_is_branch    = i.br;
        ex_pc           = i.pc;
        ex_taken        = i.tk;
        ex_target       = i.tgt;
        ex_pred_opinion = i.op;
        ex_pred_taken   = i.pt;
        ex_pred_addr    = i.pa;
    endtask

    task automatic step(input in_t i, input exp_t e, input string tag);
        exp_t got;
        drive(i);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got = sb.pop_front();
            compare(got, tag);
        end
    endtask

    initial begin
        in_t  z;
        exp_t e0;
        z  = mi(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        e0 = me(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        drive(z);

        // correct not-taken
        vt[0]  = '{mi(0,1,1,32'h100,0,32'h0,0,0,32'h0),
                   me(1,0,32'h0,32'h100,0,32'h0,0,1,0)};
        // idle: pulses clear, data holds
        vt[1]  = '{mi(0,0,1,32'h180,1,32'h1,1,1,32'h2),
                   me(0,0,32'h0,32'h100,0,32'h0,0,1,0)};
        // predicted not-taken, actually taken
        vt[2]  = '{mi(0,1,1,32'h200,1,32'h400,0,0,32'h0),
                   me(1,1,32'h400,32'h200,1,32'h400,1,2,1)};
        // two flush cycles: mispredicting branch ignored
        vt[3]  = '{mi(0,1,1,32'h900,1,32'h999,0,0,32'h0),
                   me(0,1,32'h400,32'h200,0,32'h400,1,2,1)};
        vt[4]  = '{mi(0,1,1,32'h900,1,32'h999,0,0,32'h0),
                   me(0,1,32'h400,32'h200,0,32'h400,0,2,1)};
        // predicted taken to wrong target
        vt[5]  = '{mi(0,1,1,32'h40,1,32'h600,1,1,32'h500),
                   me(1,1,32'h600,32'h40,1,32'h600,1,3,2)};
        // valid branches during flush ignored
        vt[6]  = '{mi(0,1,1,32'h50,0,32'h0,0,0,32'h0),
                   me(0,1,32'h600,32'h40,0,32'h600,1,3,2)};
        vt[7]  = '{mi(0,1,1,32'h54,0,32'h0,0,0,32'h0),
                   me(0,1,32'h600,32'h40,0,32'h600,0,3,2)};
        // stale hit on non-branch
        vt[8]  = '{mi(0,1,0,32'h300,0,32'h0,1,1,32'h800),
                   me(0,1,32'h600,32'h40,1,32'h304,1,3,3)};
        vt[9]  = '{mi(0,0,0,32'h0,0,32'h0,0,0,32'h0),
                   me(0,1,32'h600,32'h40,0,32'h304,1,3,3)};
        vt[10] = '{mi(0,0,0,32'h0,0,32'h0,0,0,32'h0),
                   me(0,1,32'h600,32'h40,0,32'h304,0,3,3)};
        // pc+4 wraps to zero
        vt[11] = '{mi(0,1,1,32'hFFFFFFFC,0,32'h0,1,1,32'h10),
                   me(1,0,32'h0,32'hFFFFFFFC,1,32'h0,1,4,4)};
        vt[12] = '{mi(0,0,0,32'h0,0,32'h0,0,0,32'h0),
                   me(0,0,32'h0,32'hFFFFFFFC,0,32'h0,1,4,4)};
        vt[13] = '{mi(0,0,0,32'h0,0,32'h0,0,0,32'h0),
                   me(0,0,32'h0,32'hFFFFFFFC,0,32'h0,0,4,4)};
        // first IDLE cycle: correct taken prediction accepted
        vt[14] = '{mi(0,1,1,32'h60,1,32'h700,1,1,32'h700),
                   me(1,1,32'h700,32'h60,0,32'h0,0,5,4)};

        step(z, e0, "reset0");
        step(z, e0, "reset1");

        for (int k = 0; k < 15; k++) begin
            step(vt[k].i, vt[k].e, $sformatf("vec%0d", k));
        end

        // reset during the first flush cycle
        step(mi(0,1,1,32'h200,1,32'h400,0,0,32'h0),
             me(1,1,32'h400,32'h200,1,32'h400,1,6,5), "mid_mp");
        step(mi(1,1,1,32'h200,1,32'h400,0,0,32'h0),
             e0, "mid_rst");
        step(mi(0,1,1,32'h100,0,32'h0,0,0,32'h0),
             me(1,0,32'h0,32'h100,0,32'h0,0,1,0), "post_rst");

        // saturation on the 2-bit counter instance
        begin
            exp_t e;
            e = e0;
            e.sat = 1'b1;
            step(z, e, "sat_rst");
            for (int k = 0; k < 5; k++) begin
                logic [31:0] p;
                p = 32'h1000 + 32'(k) * 32'd4;
                e = me(1,0,32'h0,p,0,32'h0,0,32'(k + 1),0);
                e.sat = 1'b1;
                e.bc2 = (k >= 2) ? 2'd3 : 2'(k + 1);
                e.mc2 = 2'd0;
                step(mi(0,1,1,p,0,32'h0,0,0,32'h0), e,
                     $sformatf("sat%0d", k));
            end
        end

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
